noc_credit_sink: RTL and testbench
==================================

Name: noc_credit_sink

Overview:
- Receive end of the router's credit-based output link.
- Accepts flits qualified by a valid strobe from a router output port (north/south/east/west/local) and buffers them in a FIFO that sits in front of the consumer.
- Consumer pops use a valid/ready handshake.
- Returns exactly one credit pulse per freed slot on incr_o. incr_o drives the upstream router's matching *_incr_i, closing the flow-control loop with the router's credit counter (fcc).

Parameters:
- DATA_W, 32, flit width in bits.
- DEPTH, 4, FIFO slots. This equals the credit count the upstream fcc is reset to; DEPTH >= 2, need not be a power of 2.
- ADDR_LSB, 0, bit position of the destination-address field within the flit.
- ADDR_W, 4, destination-address field width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flit_i  input  DATA_W  flit from router output (e.g. local_o).
- valid_i  input  1  flit strobe from router (e.g. valid_l_o); one flit per high cycle.
- incr_o  output  1  credit-return pulse to upstream *_incr_i.
- data_o  output  DATA_W  head-of-FIFO flit.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts head flit.
- count_o  output  CNT_W  current occupancy.
- overflow_o  output  1  sticky: a flit arrived with no free slot.
- myaddr_i  input  ADDR_W  this node's address; used only with the optional feature.
- misroute_o  output  1  sticky misroute flag; used only with the optional feature.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, count and all storage-valid state go to 0.
  - incr_o, valid_o, overflow_o and misroute_o are 0. count_o is 0. data_o is 0.
- Push and pop:
  - push = valid_i. pop = valid_o & ready_i.
- FIFO and latency:
  - First-word-fall-through.
  - A flit pushed in cycle N appears on data_o with valid_o=1 in cycle N+1.
  - data_o holds its value while valid_o=1 and ready_i=0.
- Pointers: wrap explicitly from DEPTH-1 to 0; no power-of-2 reliance.
- Occupancy:
  - count updates as +1 on push only, -1 on pop only, unchanged on push+pop.
  - count_o is registered.
- Full:
  - If count == DEPTH and push with no pop, the flit is dropped and overflow_o sets from the next cycle.
  - overflow_o stays set until rst.
  - Pointers and count are unchanged.
- Full with simultaneous push and pop: the push is accepted, the head is popped, and count stays at DEPTH.
- Empty: ready_i is ignored, there is no pop, and no credit is issued.
- Empty with simultaneous push and ready: no pop that cycle; the flit appears in the next cycle.
- Credit return:
  - incr_o is a registered copy of pop, asserted for exactly the cycle after each pop.
  - Back-to-back pops hold incr_o high continuously, one cycle per pop.
  - Total incr_o pulses always equal total pops. Dropped (overflow) flits never generate credit.
- Reset mid-operation clears all contents. Any in-flight incr_o pulse is cancelled, and the upstream fcc must be reset together with this block.
- State: there is no FSM beyond the FIFO pointers, count, credit register and sticky flags.

Optional Feature:
- Macro: NOC_SINK_ADDR_CHECK_EN.
- When defined:
  - On every accepted push, compare flit_i[ADDR_LSB +: ADDR_W] with myaddr_i.
  - On mismatch, misroute_o sets from the next cycle and stays set until rst.
  - The flit is still stored and credited, so flow control stays consistent.
- When undefined:
  - misroute_o is tied 0 and myaddr_i is unused.
  - Port list is identical.

Test Plan:
1. Reset with rst=1 mid-stream, DEPTH=4, after 2 pushes -> next cycle count_o=0, valid_o=0, incr_o=0, overflow_o=0; a flit pushed after release reads back correctly.
2. Push 0xA1,0xA2,0xA3 on consecutive cycles with ready_i=0 -> count_o=3; ready_i=1 for 3 cycles yields data_o 0xA1,0xA2,0xA3 in order; incr_o high for exactly 3 cycles, each one cycle after its pop.
3. Fill 4 flits, then push 0xFF with ready_i=0 -> 0xFF dropped, count_o stays 4, overflow_o=1 from the next cycle and held; draining returns exactly 4 credits.
4. Full (count=4), push 0xB5 with ready_i=1 in the same cycle -> head popped, 0xB5 stored, count_o stays 4, overflow_o stays 0, one incr_o pulse.
5. Stream 10 flits with a push every cycle and ready_i always 1 -> each flit on data_o one cycle after push, pointers wrap at 3->0, count_o never exceeds 1, 10 incr_o pulses.
6. With NOC_SINK_ADDR_CHECK_EN defined, myaddr_i=4'h5 -> flit 0x05 leaves misroute_o=0; flit 0x03 sets misroute_o=1 next cycle, the flit is still stored, and its pop still gives an incr_o pulse.

Source files
------------

// File: rtl/noc_credit_sink.sv
// Receive end of a credit-based NoC link: FWFT FIFO with one credit pulse per popped flit.
// Optional destination-address check enabled by defining NOC_SINK_ADDR_CHECK_EN.
module noc_credit_sink #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int ADDR_LSB = 0,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] flit_i,
  input  logic              valid_i,
  output logic              incr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  input  logic [ADDR_W-1:0] myaddr_i,
  output logic              misroute_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_incr;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_W'(DEPTH));
    w_pop   = !w_empty && ready_i;
    w_push  = valid_i && (!w_full || w_pop);
    w_drop  = valid_i && w_full && !w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_incr     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_incr <= w_pop;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wrPtr] <= flit_i;
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign incr_o     = r_incr;
  assign valid_o    = !w_empty;
  assign data_o     = w_empty ? '0 : r_mem[r_rdPtr];
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

`ifdef NOC_SINK_ADDR_CHECK_EN
  logic r_misroute;

  // Misrouted flits are still stored and credited so the upstream counter stays in step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misroute <= 1'b0;
    end else if (w_push && (flit_i[ADDR_LSB +: ADDR_W] != myaddr_i)) begin
      r_misroute <= 1'b1;
    end
  end

  assign misroute_o = r_misroute;
`else
  logic w_unusedAddr;

  assign w_unusedAddr = ^{myaddr_i, flit_i[ADDR_LSB +: ADDR_W]};
  assign misroute_o   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_sink.sv
// Directed self-checking bench for noc_credit_sink (DEPTH=4, DATA_W=32).
module tb_noc_credit_sink;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] flit_i;
  logic              valid_i;
  logic              incr_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic [3:0]        myaddr_i;
  logic              misroute_o;

  int checks;
  int errors;
  int creditCount;

  noc_credit_sink #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .ADDR_LSB(0),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flit_i(flit_i),
    .valid_i(valid_i),
    .incr_o(incr_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .myaddr_i(myaddr_i),
    .misroute_o(misroute_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Credit pulses are tallied mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (incr_o === 1'b1) creditCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] f, input logic r);
    valid_i = v;
    flit_i  = f;
    ready_i = r;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    creditCount = 0;
    myaddr_i    = 4'h5;
    doReset();

    checkOutput("rst_count", 32'(count_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_incr", 32'(incr_o), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
    checkOutput("rst_data", data_o, 32'h0);
    checkOutput("rst_misroute", 32'(misroute_o), 32'd0);

    // Test 1: reset mid-stream after two pushes
    applyStimulus(1'b1, 32'h11, 1'b0); tick();
    applyStimulus(1'b1, 32'h12, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_count2", 32'(count_o), 32'd2);
    rst = 1'b1; tick();
    checkOutput("t1_count0", 32'(count_o), 32'd0);
    checkOutput("t1_valid0", 32'(valid_o), 32'd0);
    checkOutput("t1_incr0", 32'(incr_o), 32'd0);
    checkOutput("t1_ovf0", 32'(overflow_o), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h33, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_valid1", 32'(valid_o), 32'd1);
    checkOutput("t1_data", data_o, 32'h33);
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkOutput("t1_popcount", 32'(count_o), 32'd0);
    checkOutput("t1_incr", 32'(incr_o), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0); tick();
    checkOutput("t1_incr_end", 32'(incr_o), 32'd0);

    // Empty: ready alone must not pop or credit
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkOutput("empty_incr", 32'(incr_o), 32'd0);
    checkOutput("empty_count", 32'(count_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Test 2: three pushes, then three pops in order
    applyStimulus(1'b1, 32'hA1, 1'b0); tick();
    applyStimulus(1'b1, 32'hA2, 1'b0); tick();
    applyStimulus(1'b1, 32'hA3, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_count3", 32'(count_o), 32'd3);
    checkOutput("t2_incr_idle", 32'(incr_o), 32'd0);
    creditCount = 0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2_head0", data_o, 32'hA1); tick();
    checkOutput("t2_head1", data_o, 32'hA2);
    checkOutput("t2_incr1", 32'(incr_o), 32'd1); tick();
    checkOutput("t2_head2", data_o, 32'hA3);
    checkOutput("t2_incr2", 32'(incr_o), 32'd1); tick();
    checkOutput("t2_incr3", 32'(incr_o), 32'd1);
    checkOutput("t2_empty", 32'(valid_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0); tick();
    checkOutput("t2_incr_off", 32'(incr_o), 32'd0);
    checkOutput("t2_credits", 32'(creditCount), 32'd3);

    // Test 3: overflow drops the flit and sets the sticky flag
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hC1 + 32'(i), 1'b0); tick();
    end
    checkOutput("t3_full", 32'(count_o), 32'd4);
    checkOutput("t3_ovf_pre", 32'(overflow_o), 32'd0);
    applyStimulus(1'b1, 32'hFF, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_count", 32'(count_o), 32'd4);
    checkOutput("t3_ovf", 32'(overflow_o), 32'd1);
    checkOutput("t3_incr_drop", 32'(incr_o), 32'd0);
    tick();
    checkOutput("t3_ovf_hold", 32'(overflow_o), 32'd1);
    creditCount = 0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_drain", data_o, 32'hC1 + 32'(i)); tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_count0", 32'(count_o), 32'd0);
    tick();
    checkOutput("t3_credits", 32'(creditCount), 32'd4);
    checkOutput("t3_ovf_sticky", 32'(overflow_o), 32'd1);

    // Test 4: full with simultaneous push and pop
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hD1 + 32'(i), 1'b0); tick();
    end
    creditCount = 0;
    applyStimulus(1'b1, 32'hB5, 1'b1); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_count", 32'(count_o), 32'd4);
    checkOutput("t4_ovf", 32'(overflow_o), 32'd0);
    checkOutput("t4_incr", 32'(incr_o), 32'd1);
    checkOutput("t4_head", data_o, 32'hD2);
    tick();
    checkOutput("t4_incr_off", 32'(incr_o), 32'd0);
    checkOutput("t4_credits", 32'(creditCount), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4_d2", data_o, 32'hD2); tick();
    checkOutput("t4_d3", data_o, 32'hD3); tick();
    checkOutput("t4_d4", data_o, 32'hD4); tick();
    checkOutput("t4_b5", data_o, 32'hB5); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_empty", 32'(count_o), 32'd0);

    // Test 5: streaming, one push and one pop per cycle across pointer wraps
    tick();
    creditCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'hE0 + 32'(i), 1'b1); tick();
      checkOutput("t5_data", data_o, 32'hE0 + 32'(i));
      checkOutput("t5_count", 32'(count_o), 32'd1);
      checkOutput("t5_incr", 32'(incr_o), (i == 0) ? 32'd0 : 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1); tick();
    checkOutput("t5_drained", 32'(count_o), 32'd0);
    checkOutput("t5_last_incr", 32'(incr_o), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0); tick();
    checkOutput("t5_credits", 32'(creditCount), 32'd10);

    // Test 6: address check
    creditCount = 0;
    applyStimulus(1'b1, 32'h05, 1'b0); tick();
    checkOutput("t6_match", 32'(misroute_o), 32'd0);
    applyStimulus(1'b1, 32'h03, 1'b0); tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
`ifdef NOC_SINK_ADDR_CHECK_EN
    checkOutput("t6_misroute", 32'(misroute_o), 32'd1);
`else
    checkOutput("t6_tied0", 32'(misroute_o), 32'd0);
`endif
    checkOutput("t6_stored", 32'(count_o), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_h0", data_o, 32'h05); tick();
    checkOutput("t6_h1", data_o, 32'h03); tick();
    applyStimulus(1'b0, 32'h0, 1'b0); tick();
    checkOutput("t6_credits", 32'(creditCount), 32'd2);
`ifdef NOC_SINK_ADDR_CHECK_EN
    checkOutput("t6_sticky", 32'(misroute_o), 32'd1);
`else
    checkOutput("t6_still0", 32'(misroute_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
